// File: rtl/lsu_axi_aligned.sv
// Load/store unit: effective address, natural-alignment check, single-outstanding
// AXI-lite master with byte-lane positioning and load extension.
module lsu_axi_aligned #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64,
    localparam int STRB_W = XLEN / 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_req,
    input  logic                st_req,
    output logic                req_ready,
    input  logic [2:0]          func3,
    input  logic [XLEN-1:0]     src1,
    input  logic [XLEN-1:0]     src2,
    input  logic [XLEN-1:0]     imm,
    input  logic [4:0]          dst_id,
    input  logic                dst_vld,
    output logic                resp_vld,
    output logic                wb_vld,
    output logic [4:0]          wb_addr,
    output logic [XLEN-1:0]     wb_data,
    output logic                exc_vld,
    output logic [3:0]          exc_code,
    output logic [ADDR_W-1:0]   exc_addr,
    output logic [ADDR_W-1:0]   axi_AW_ADDR,
    output logic                axi_AW_VALID,
    input  logic                axi_AW_READY,
    output logic [XLEN-1:0]     axi_W_DATA,
    output logic [STRB_W-1:0]   axi_W_STRB,
    output logic                axi_W_VALID,
    input  logic                axi_W_READY,
    input  logic [1:0]          axi_B_RESP,
    input  logic                axi_B_VALID,
    output logic                axi_B_READY,
    output logic [ADDR_W-1:0]   axi_AR_ADDR,
    output logic                axi_AR_VALID,
    input  logic                axi_AR_READY,
    input  logic [XLEN-1:0]     axi_R_DATA,
    input  logic [1:0]          axi_R_RESP,
    input  logic                axi_R_VALID,
    output logic                axi_R_READY
);
    localparam int OFF_W = $clog2(STRB_W);

    typedef enum logic [2:0] {IDLE, AR, R, AWW, B, RESP} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  ea_q;
    logic [2:0]         f3_q;
    logic [4:0]         dst_id_q;
    logic               dst_vld_q;

    logic [XLEN-1:0]    sum;
    logic [ADDR_W-1:0]  ea_in;
    logic [OFF_W-1:0]   off_in;
    logic               mis_in;

    assign sum    = src1 + imm;
    assign ea_in  = ADDR_W'(sum);
    assign off_in = ea_in[OFF_W-1:0];

    always_comb begin
        mis_in = 1'b0;
        case (func3[1:0])
            2'd0:    mis_in = 1'b0;
            2'd1:    mis_in = ea_in[0];
            2'd2:    mis_in = |ea_in[1:0];
            default: mis_in = (|ea_in[2:0]) || (STRB_W < 8);
        endcase
    end

    function automatic logic [STRB_W-1:0] lane_strb(input logic [OFF_W-1:0] off,
                                                    input logic [1:0] size);
        logic [STRB_W-1:0] s;
        int nb;
        nb = 1 << size;
        for (int i = 0; i < STRB_W; i++)
            s[i] = (i >= int'(off)) && (i < int'(off) + nb);
        return s;
    endfunction

    // Shift the addressed lane down, then sign/zero extend from its top bit.
    function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] d,
                                                 input logic [OFF_W-1:0] off,
                                                 input logic [2:0] f3);
        logic [XLEN-1:0] sh, r;
        logic sb;
        int nbits;
        sh    = d >> {off, 3'b000};
        nbits = 8 << f3[1:0];
        case (f3[1:0])
            2'd0:    sb = sh[7];
            2'd1:    sb = sh[15];
            2'd2:    sb = sh[31];
            default: sb = sh[XLEN-1];
        endcase
        sb = sb & ~f3[2];
        for (int i = 0; i < XLEN; i++)
            r[i] = (i < nbits) ? sh[i] : sb;
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ea_q         <= '0;
            f3_q         <= '0;
            dst_id_q     <= '0;
            dst_vld_q    <= 1'b0;
            req_ready    <= 1'b1;
            resp_vld     <= 1'b0;
            wb_vld       <= 1'b0;
            wb_addr      <= '0;
            wb_data      <= '0;
            exc_vld      <= 1'b0;
            exc_code     <= '0;
            exc_addr     <= '0;
            axi_AW_ADDR  <= '0;
            axi_AW_VALID <= 1'b0;
            axi_W_DATA   <= '0;
            axi_W_STRB   <= '0;
            axi_W_VALID  <= 1'b0;
            axi_B_READY  <= 1'b0;
            axi_AR_ADDR  <= '0;
            axi_AR_VALID <= 1'b0;
            axi_R_READY  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (ld_req || st_req) begin
                    ea_q      <= ea_in;
                    f3_q      <= func3;
                    dst_id_q  <= dst_id;
                    dst_vld_q <= dst_vld;
                    req_ready <= 1'b0;
                    if (mis_in) begin
                        state    <= RESP;
                        resp_vld <= 1'b1;
                        exc_vld  <= 1'b1;
                        exc_code <= ld_req ? 4'd4 : 4'd6;
                        exc_addr <= ea_in;
                        wb_addr  <= dst_id;
                    end else if (ld_req) begin
                        state        <= AR;
                        axi_AR_VALID <= 1'b1;
                        axi_AR_ADDR  <= {ea_in[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    end else begin
                        state        <= AWW;
                        axi_AW_VALID <= 1'b1;
                        axi_W_VALID  <= 1'b1;
                        axi_AW_ADDR  <= {ea_in[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        axi_W_DATA   <= src2 << {off_in, 3'b000};
                        axi_W_STRB   <= lane_strb(off_in, func3[1:0]);
                    end
                end
                AR: if (axi_AR_READY) begin
                    axi_AR_VALID <= 1'b0;
                    axi_R_READY  <= 1'b1;
                    state        <= R;
                end
                R: if (axi_R_VALID) begin
                    axi_R_READY <= 1'b0;
                    resp_vld    <= 1'b1;
                    wb_addr     <= dst_id_q;
                    state       <= RESP;
                    if (axi_R_RESP != 2'b00) begin
                        exc_vld  <= 1'b1;
                        exc_code <= 4'd5;
                        exc_addr <= ea_q;
                    end else begin
                        wb_vld  <= dst_vld_q;
                        wb_data <= dst_vld_q ? fmt_load(axi_R_DATA, ea_q[OFF_W-1:0], f3_q) : '0;
                    end
                end
                AWW: begin
                    // AW and W complete independently; move on once both have.
                    if (axi_AW_READY) axi_AW_VALID <= 1'b0;
                    if (axi_W_READY)  axi_W_VALID  <= 1'b0;
                    if ((!axi_AW_VALID || axi_AW_READY) && (!axi_W_VALID || axi_W_READY)) begin
                        axi_B_READY <= 1'b1;
                        state       <= B;
                    end
                end
                B: if (axi_B_VALID) begin
                    axi_B_READY <= 1'b0;
                    resp_vld    <= 1'b1;
                    wb_addr     <= dst_id_q;
                    state       <= RESP;
                    if (axi_B_RESP != 2'b00) begin
                        exc_vld  <= 1'b1;
                        exc_code <= 4'd7;
                        exc_addr <= ea_q;
                    end
                end
                default: begin
                    resp_vld  <= 1'b0;
                    wb_vld    <= 1'b0;
                    wb_addr   <= '0;
                    wb_data   <= '0;
                    exc_vld   <= 1'b0;
                    exc_code  <= '0;
                    exc_addr  <= '0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/lsu_axi_aligned.md
Name: lsu_axi_aligned

Overview:
- Parametrised next-generation load/store unit in the EXU.
- Computes the effective address and checks natural alignment.
- Drives a single-outstanding AXI-lite master directly:
  - positions store bytes and strobes by address offset;
  - extracts and sign- or zero-extends load data by address offset.
- Reports load writeback, completion and precise exceptions (misaligned, bus error) back to the pipeline.

Parameters:
- XLEN, 64, register/bus data width in bits; 32 or 64.
- ADDR_W, 64, address width in bits.
- STRB_W, XLEN/8, derived, byte-strobe width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ld_req  in  1  load request, qualified by req_ready
- st_req  in  1  store request, qualified by req_ready
- req_ready  out  1  high only in IDLE
- func3  in  3  RISC-V funct3: [1:0] size, [2] unsigned (loads)
- src1  in  XLEN  base register
- src2  in  XLEN  store data
- imm  in  XLEN  offset
- dst_id  in  5  load destination register
- dst_vld  in  1  destination writes a register
- resp_vld  out  1  one-cycle completion pulse
- wb_vld  out  1  register writeback valid
- wb_addr  out  5  writeback register
- wb_data  out  XLEN  extended load data
- exc_vld  out  1  exception with resp_vld
- exc_code  out  4  4 load-misaligned, 5 load-fault, 6 store-misaligned, 7 store-fault
- exc_addr  out  ADDR_W  faulting effective address
- axi_AW_ADDR  out  ADDR_W
- axi_AW_VALID  out  1
- axi_AW_READY  in  1
- axi_W_DATA  out  XLEN
- axi_W_STRB  out  STRB_W
- axi_W_VALID  out  1
- axi_W_READY  in  1
- axi_B_RESP  in  2
- axi_B_VALID  in  1
- axi_B_READY  out  1
- axi_AR_ADDR  out  ADDR_W
- axi_AR_VALID  out  1
- axi_AR_READY  in  1
- axi_R_DATA  in  XLEN
- axi_R_RESP  in  2
- axi_R_VALID  in  1
- axi_R_READY  out  1

Behaviour:
- Reset (async, immediate):
  - State returns to IDLE; req_ready=1.
  - Every other output is 0, including all VALID/READY, resp_vld, wb_vld and exc_vld. A transaction in flight is abandoned.
- Request acceptance:
  - A request is accepted at (ld_req|st_req)&req_ready.
  - At acceptance, latch: ea=(src1+imm) truncated to ADDR_W; func3; dst_id; dst_vld; src2; op type.
  - If ld_req and st_req are high together, the load wins.
- Alignment check:
  - nbytes=1<<func3[1:0]; off=ea mod STRB_W.
  - Misaligned if ea&(nbytes-1)≠0, or if nbytes>STRB_W.
  - Misaligned requests go to state RESP with no bus activity: resp_vld and exc_vld assert the cycle after acceptance, exc_addr=ea.
- State machine:
  - IDLE: accept a request; go to RESP (misaligned), AR (load) or AWW (store).
  - AR: axi_AR_VALID=1, axi_AR_ADDR=ea with low log2(STRB_W) bits cleared. Held stable until AR_READY, then go to R.
  - R: axi_R_READY=1. On R_VALID, capture data and RESP, then go to RESP.
  - AWW:
    - Both axi_AW_VALID and axi_W_VALID assert on entry, and each drops independently after its own handshake.
    - Leave AWW for B once both have completed; this may be the same cycle or different cycles.
    - AW_ADDR is aligned the same way as AR_ADDR.
    - W_DATA=src2<<(8*off).
    - W_STRB=((1<<nbytes)-1)<<off.
  - B: axi_B_READY=1. On B_VALID, capture RESP, then go to RESP.
  - RESP: outputs valid for exactly one cycle, then go to IDLE. req_ready goes high in the cycle after the resp_vld pulse.
- Load data formatting:
  - sh=R_DATA>>(8*off), take the low nbytes.
  - func3[2]=0 sign-extends to XLEN; func3[2]=1 zero-extends.
  - func3=011 on XLEN=32 is misaligned/illegal.
- Response outputs during the RESP pulse:
  - wb_vld = load & dst_vld & ~exc_vld.
  - wb_addr = latched dst_id.
  - A RESP value ≠0 on R or B gives exc_vld=1 with code 5 (load) or 7 (store).
  - wb_data is 0 whenever wb_vld=0.
- Latency:
  - Zero-wait load: accept at T, AR at T+1, R at T+2, resp_vld at T+3.
  - Zero-wait store: accept at T, AW+W at T+1, B at T+2, resp_vld at T+3.
  - Misaligned access: resp_vld at T+1.
- AXI rules:
  - VALID never drops before READY.
  - Address and data stay stable while VALID is high.
  - Early READY on either channel is tolerated.

Test Plan:
- XLEN=64, lb at ea=0x1003, R_DATA=0x0000_0000_80FF_0000 (byte 3 = 0x80) -> AR_ADDR=0x1000; wb_data=0xFFFF_FFFF_FFFF_FF80; wb_vld=1; resp_vld at T+3.
- lhu at ea=0x2006, R_DATA=0xBEEF_0000_0000_0000 -> wb_data=0xBEEF.
- sh src2=0x1234 at ea=0x3002, AW_READY delayed 3 cycles, W_READY immediate -> W_STRB=0x0C, W_DATA=0x0000_0000_1234_0000; resp_vld only after the B handshake; wb_vld=0.
- lw at ea=0x4002 -> no AR_VALID; resp_vld and exc_vld at T+1, exc_code=4, exc_addr=0x4002.
- sd with B_RESP=2'b10 -> exc_vld=1, exc_code=7; ld with R_RESP=2'b11 -> exc_code=5, wb_vld=0.
- rst asserted while in R with R_VALID pending -> R_READY=0 and req_ready=1 immediately; a following load completes normally.
